sw_debounce: RTL and testbench
==============================

// Module: sw_debounce
// PURPOSE
//  Input-side conditioner for the board top. It synchronises and debounces the
//  raw slide switches and push-buttons (sw_i[15:0]) before they reach the
//  display-select, clock-speed and reset logic.
//  Produces stable levels plus one-cycle rise/fall pulses per bit. These form
//  the input path that complements the seg7x16 output path.
// PARAMETERS
//  WIDTH            16      number of independent input bits
//  SYNC_STAGES      2       flops in the metastability chain (>=2)
//  DEBOUNCE_CYCLES  500000  consecutive stable samples required (>=2)
// PORTS
//  clk        in   1      system clock; all logic on rising edge
//  rstn       in   1      asynchronous active-low reset
//  sw_raw     in   WIDTH  asynchronous switch/button pins
//  sw_o       out  WIDTH  debounced stable level
//  sw_rise    out  WIDTH  1-cycle pulse when sw_o[i] goes 0->1
//  sw_fall    out  WIDTH  1-cycle pulse when sw_o[i] goes 1->0
//  chg_flag   out  1      sticky "any bit changed" (see CONFIGURATION)
//  chg_ack    in   1      clears chg_flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rstn=0, async): sync chain, counters, sw_o, sw_rise, sw_fall and
//    chg_flag all go to 0 immediately. Reset mid-count discards progress.
//  - Per bit i: sync[i] is sw_raw[i] after SYNC_STAGES flops.
//    cnt[i] is $clog2(DEBOUNCE_CYCLES) bits wide, unsigned.
//  - Each rising edge, per bit:
//      sync==sw_o                  : cnt<=0
//      sync!=sw_o, cnt<DEBOUNCE_CYCLES-1 : cnt<=cnt+1
//      sync!=sw_o, cnt==DEBOUNCE_CYCLES-1: sw_o<=sync, cnt<=0, pulse
//  - Any single sample equal to sw_o restarts the count (glitch rejection).
//  - The counter never wraps; it saturates by construction at D-1.
//  - Latency: the first edge sampling the new level is edge 1. sw_o changes
//    on edge SYNC_STAGES+DEBOUNCE_CYCLES.
//  - sw_rise[i]/sw_fall[i] are registered and assert in the same cycle sw_o[i]
//    changes, for exactly one cycle. The two are never high together for one bit.
//  - Bits are fully independent. Simultaneous changes on several bits yield
//    simultaneous pulses.
//  - After reset with a pin held high, sw_o rises after the full latency and
//    a sw_rise pulse is generated (no reset-time preload).
// CONFIGURATION
//  Macro SW_DEBOUNCE_IRQ_EN:
//   defined:
//    - chg_flag sets on the edge after any sw_rise|sw_fall bit is 1.
//    - chg_flag clears on the edge where chg_ack=1.
//    - If a set and a clear fall on the same edge, set wins (no lost event).
//    - Reset value is 0.
//   undefined: chg_flag tied 0, chg_ack ignored, no flop inferred.
// STRUCTURE
//  - Shared header sw_debounce_def.v, included like signal_def.v. It holds the
//    default SYNC_STAGES/DEBOUNCE_CYCLES and a `SIM_DEBOUNCE_CYCLES = 4 value
//    for simulation builds.
//  - One sub-module, sw_debounce_bit: sync chain, counter, stable flop and
//    pulse flops for 1 bit. The top generates WIDTH instances and adds the
//    optional chg_flag logic.
// TESTING  (SYNC_STAGES=2, DEBOUNCE_CYCLES=4)
//  1. Reset: hold rstn=0 with sw_raw=16'hFFFF.
//     -> sw_o=0, pulses=0, chg_flag=0.
//     Release rstn -> sw_o=16'hFFFF on edge 6, sw_rise=16'hFFFF for 1 cycle.
//  2. Clean step: sw_raw[3] goes 0->1 before edge 1 and is held.
//     -> sw_o[3]=1 after edge 6, sw_rise[3]=1 for exactly that cycle.
//     No other bit changes.
//  3. Glitch: sw_raw[0] high for 3 cycles, then low.
//     -> sw_o[0] stays 0 and no pulse occurs.
//     Bouncing 1,0,1,1,1,1 -> sw_o[0] rises 4 edges after the last 0 leaves
//     the sync chain.
//  4. Fall plus simultaneous bits: sw_raw 16'h8001 -> 16'h0000 with both bits
//     stable. -> sw_fall=16'h8001 in one cycle, sw_o=16'h0000.
//  5. Mid-count reset: pulse rstn low at edge 4 of a pending change.
//     -> all outputs 0. After release the full 6-edge latency restarts.
//  6. SW_DEBOUNCE_IRQ_EN: a change sets chg_flag.
//     chg_ack=1 alone -> flag 0 next edge.
//     chg_ack=1 on the same edge as a new pulse -> flag stays 1.
//     Without the macro, chg_flag stays 0 throughout.

Source files
------------

// File: rtl/sw_debounce_pkg.sv
// sw_debounce_pkg
//   Shared build constants and types for the switch/button input conditioner.
//   SW_DEB_SIM_CYCLES is the short debounce window used by simulation builds
//   (override DEBOUNCE_CYCLES with it); the other values are board defaults.
package sw_debounce_pkg;

  localparam int unsigned SW_DEB_WIDTH       = 16;
  localparam int unsigned SW_DEB_SYNC_STAGES = 2;
  localparam int unsigned SW_DEB_CYCLES      = 500000;
  localparam int unsigned SW_DEB_SIM_CYCLES  = 4;

  // Per-bit event committed on a given edge.
  typedef enum logic [1:0] {
    EDGE_NONE = 2'd0,
    EDGE_RISE = 2'd1,
    EDGE_FALL = 2'd2
  } edge_e;

endpackage

// File: rtl/sw_debounce_bit.sv
// sw_debounce_bit
//   One input bit: SYNC_STAGES-flop synchroniser, stability counter, debounced
//   level flop and registered rise/fall pulses.
// Ports
//   clk      in   system clock, rising edge
//   rstn     in   asynchronous active-low reset
//   sw_raw   in   asynchronous pin
//   sw_o     out  debounced level
//   sw_rise  out  one-cycle pulse, same cycle sw_o goes 0->1
//   sw_fall  out  one-cycle pulse, same cycle sw_o goes 1->0
module sw_debounce_bit
  import sw_debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SW_DEB_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = SW_DEB_CYCLES
) (
  input  logic clk,
  input  logic rstn,
  input  logic sw_raw,
  output logic sw_o,
  output logic sw_rise,
  output logic sw_fall
);

  localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic                   stable_d;
  edge_e                  edge_d;

  assign sync = sync_q[SYNC_STAGES-1];

  // Any sample matching the current level restarts the count; the counter
  // commits on reaching CNT_LAST, so it never needs to wrap.
  always_comb begin
    cnt_d    = '0;
    stable_d = sw_o;
    edge_d   = EDGE_NONE;
    if (sync != sw_o) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync;
        edge_d   = sync ? EDGE_RISE : EDGE_FALL;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      sw_o    <= 1'b0;
      sw_rise <= 1'b0;
      sw_fall <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], sw_raw};
      cnt_q   <= cnt_d;
      sw_o    <= stable_d;
      sw_rise <= (edge_d == EDGE_RISE);
      sw_fall <= (edge_d == EDGE_FALL);
    end
  end

endmodule

// File: rtl/sw_debounce.sv
// sw_debounce
//   Synchronises and debounces WIDTH raw switch/button pins. Produces stable
//   levels plus one-cycle rise/fall pulses per bit.
//   Build option: define SW_DEBOUNCE_IRQ_EN to enable the sticky chg_flag
//   (set by any pulse, cleared by chg_ack, set wins). Undefined: chg_flag = 0.
// Ports
//   clk       in   system clock, rising edge
//   rstn      in   asynchronous active-low reset
//   sw_raw    in   [WIDTH] asynchronous pins
//   sw_o      out  [WIDTH] debounced levels
//   sw_rise   out  [WIDTH] rise pulses
//   sw_fall   out  [WIDTH] fall pulses
//   chg_flag  out  sticky "any bit changed"
//   chg_ack   in   clears chg_flag
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int unsigned WIDTH           = SW_DEB_WIDTH,
  parameter int unsigned SYNC_STAGES     = SW_DEB_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = SW_DEB_CYCLES
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_o,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             chg_flag,
  input  logic             chg_ack
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sw_debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk    (clk),
      .rstn   (rstn),
      .sw_raw (sw_raw[i]),
      .sw_o   (sw_o[i]),
      .sw_rise(sw_rise[i]),
      .sw_fall(sw_fall[i])
    );
  end

`ifdef SW_DEBOUNCE_IRQ_EN
  logic any_pulse;
  assign any_pulse = |(sw_rise | sw_fall);

  // Set is checked first so an ack coinciding with a new event keeps the flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      chg_flag <= 1'b0;
    end else if (any_pulse) begin
      chg_flag <= 1'b1;
    end else if (chg_ack) begin
      chg_flag <= 1'b0;
    end
  end
`else
  logic unused_chg_ack;
  assign unused_chg_ack = chg_ack;
  assign chg_flag       = 1'b0;
`endif

endmodule

// File: tb/tb_sw_debounce.sv
module tb_sw_debounce;
  import sw_debounce_pkg::*;

  localparam int unsigned LAT = 6;  // SYNC_STAGES + DEBOUNCE_CYCLES

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [15:0] sw_raw = '0;
  logic [15:0] sw_o, sw_rise, sw_fall;
  logic        chg_flag;
  logic        chg_ack = 1'b0;

  sw_debounce #(
    .WIDTH          (16),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(SW_DEB_SIM_CYCLES)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .sw_raw  (sw_raw),
    .sw_o    (sw_o),
    .sw_rise (sw_rise),
    .sw_fall (sw_fall),
    .chg_flag(chg_flag),
    .chg_ack (chg_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] o;
    logic [15:0] rise;
    logic [15:0] fall;
    logic        flag;
  } exp_t;

  typedef struct {
    logic [15:0] raw;
    int unsigned hold;
    logic [15:0] exp_o;
    logic [15:0] exp_rise;
    logic [15:0] exp_fall;
  } vec_t;

  exp_t        sb[$];
  int          tests = 0;
  int          failed = 0;
  logic [15:0] cur_o = '0;
  logic        flag_m = 1'b0;
  logic        pulse_prev = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge; drives one cycle, checks after the next rising edge,
  // returns at the following negedge.
  task automatic step(input logic [15:0] raw, input logic ack,
                      input logic [15:0] e_o, input logic [15:0] e_r, input logic [15:0] e_f);
    exp_t e, got;
    sw_raw  = raw;
    chg_ack = ack;
`ifdef SW_DEBOUNCE_IRQ_EN
    flag_m = pulse_prev ? 1'b1 : (ack ? 1'b0 : flag_m);
`else
    flag_m = 1'b0;
`endif
    pulse_prev = |(e_r | e_f);
    e.o = e_o; e.rise = e_r; e.fall = e_f; e.flag = flag_m;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      tests++; failed++;
      $display("FAIL scoreboard: empty queue at %0t", $time);
    end else begin
      got = sb.pop_front();
      check("sw_o", sw_o, got.o);
      check("sw_rise", sw_rise, got.rise);
      check("sw_fall", sw_fall, got.fall);
      check("chg_flag", {15'd0, chg_flag}, {15'd0, got.flag});
    end
    @(negedge clk);
  endtask

  // Clean level change held for 'hold' edges; commit lands on edge LAT.
  task automatic seg(input vec_t v);
    for (int unsigned k = 1; k <= v.hold; k++) begin
      if (k < LAT)       step(v.raw, 1'b0, cur_o, '0, '0);
      else if (k == LAT) step(v.raw, 1'b0, v.exp_o, v.exp_rise, v.exp_fall);
      else               step(v.raw, 1'b0, v.exp_o, '0, '0);
    end
    cur_o = v.exp_o;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sw_o"}, sw_o, 16'h0000);
    check({tag, "_rise"}, sw_rise, 16'h0000);
    check({tag, "_fall"}, sw_fall, 16'h0000);
    check({tag, "_flag"}, {15'd0, chg_flag}, 16'h0000);
  endtask

  vec_t vecs[4];

  initial begin
    vecs[0] = '{raw: 16'hFFFF, hold: 7, exp_o: 16'hFFFF, exp_rise: 16'hFFFF, exp_fall: 16'h0000};
    vecs[1] = '{raw: 16'h8001, hold: 7, exp_o: 16'h8001, exp_rise: 16'h0000, exp_fall: 16'h7FFE};
    vecs[2] = '{raw: 16'h0000, hold: 7, exp_o: 16'h0000, exp_rise: 16'h0000, exp_fall: 16'h8001};
    vecs[3] = '{raw: 16'h0008, hold: 7, exp_o: 16'h0008, exp_rise: 16'h0008, exp_fall: 16'h0000};

    // Reset held with all pins high
    sw_raw = 16'hFFFF;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rstn = 1'b1;

    // Table: power-up rise, multi-bit fall, 8001->0000 fall, bit-3 clean step
    for (int i = 0; i < 4; i++) seg(vecs[i]);

    // Glitch: bit0 high for 3 samples only
    repeat (3) step(16'h0009, 1'b0, cur_o, '0, '0);
    repeat (5) step(16'h0008, 1'b0, cur_o, '0, '0);

    // Bounce 1,0,1,1,... on bit0: commit on edge 8
    step(16'h0009, 1'b0, cur_o, '0, '0);
    step(16'h0008, 1'b0, cur_o, '0, '0);
    for (int k = 3; k <= 7; k++) step(16'h0009, 1'b0, cur_o, '0, '0);
    step(16'h0009, 1'b0, 16'h0009, 16'h0001, '0);
    step(16'h0009, 1'b0, 16'h0009, '0, '0);
    cur_o = 16'h0009;

    // Mid-count reset: pending change, reset asserted after 3 edges
    repeat (3) step(16'h00F0, 1'b0, cur_o, '0, '0);
    rstn = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    #1;
    check_reset_outputs("midrst_hold");
    @(negedge clk);
    rstn = 1'b1;
    cur_o = '0; flag_m = 1'b0; pulse_prev = 1'b0;
    seg('{raw: 16'h00F0, hold: 7, exp_o: 16'h00F0, exp_rise: 16'h00F0, exp_fall: 16'h0000});

    // chg_ack behaviour
    step(16'h00F0, 1'b1, cur_o, '0, '0);
    for (int k = 1; k < 6; k++) step(16'h00F1, 1'b0, cur_o, '0, '0);
    step(16'h00F1, 1'b0, 16'h00F1, 16'h0001, '0);
    cur_o = 16'h00F1;
    step(16'h00F1, 1'b1, cur_o, '0, '0);
    step(16'h00F1, 1'b1, cur_o, '0, '0);
    step(16'h00F1, 1'b0, cur_o, '0, '0);

    if (sb.size() != 0) begin
      tests++; failed++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
